stopwatch_core: RTL and testbench

- MM:SS stopwatch/clock core with an integrated 4-digit multiplexed seven-segment driver.
- Divides the system clock into 1 Hz and 2 Hz tick enables.
- Normal mode: counts seconds/minutes at 1 Hz. Adjust mode: the selected field steps at 2 Hz.
- Sits between the board buttons/switches and the 7-seg display. Also exports binary mins/secs for debug.

---
 rtl/stopwatch_core.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   MM:SS stopwatch/clock core with a built-in 4-digit multiplexed
//   seven-segment driver. The system clock is divided into 2 Hz and 1 Hz
//   tick enables. In normal mode the time counts up at 1 Hz. In adjust mode
//   the selected field steps at 2 Hz.
//
// Parameters
//   CLK_HZ      system clock frequency; 2 Hz tick period is CLK_HZ/2 clocks
//               (must be even and >= 4)
//   REFRESH_DIV clocks each display digit stays enabled before advancing
//
// Ports
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous active-high reset
//   pause  in   1  level, high freezes mins/secs
//   sel    in   1  adjust field select: 0 = minutes, 1 = seconds
//   adj    in   2  nonzero selects adjust mode
//   mins   out  6  minutes 0..59, binary
//   secs   out  6  seconds 0..59, binary
//   seg    out  8  active-low segments {dp,g,f,e,d,c,b,a}, dp always off
//   an     out  4  active-low digit enables {mins tens, mins ones,
//                  secs tens, secs ones}
//
// Optional feature
//   ADJ_BLINK_EN  when defined, the digits of the field being adjusted are
//                 blanked while phase is high, so that field blinks.

module stopwatch_core #(
  parameter int CLK_HZ      = 100000000,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       sel,
  input  logic [1:0] adj,
  output logic [5:0] mins,
  output logic [5:0] secs,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int HALF  = CLK_HZ / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] divQ, divD;
  logic             phaseQ, phaseD;
  logic [5:0]       minsQ, minsD;
  logic [5:0]       secsQ, secsD;
  logic [REF_W-1:0] refQ, refD;
  logic [1:0]       idxQ, idxD;
  logic [3:0]       anQ, anD;
  logic [7:0]       segQ, segD;

  logic       tick1, tick2, adjMode;
  logic [3:0] digitVal;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [3:0] tensOf(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] onesOf(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [6:0] sevenSeg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Free-running tick generator; tick1 fires on every second tick2.
  always_comb begin
    tick2  = (divQ == DIV_LAST);
    tick1  = tick2 & phaseQ;
    divD   = tick2 ? '0 : divQ + DIV_W'(1);
    phaseD = phaseQ ^ tick2;
  end

  // Time update. Adjust mode steps only the selected field with no carry;
  // normal mode carries seconds into minutes and wraps 59:59 to 00:00.
  always_comb begin
    minsD   = minsQ;
    secsD   = secsQ;
    adjMode = |adj;
    if (!pause) begin
      if (adjMode) begin
        if (tick2) begin
          if (sel) secsD = inc60(secsQ);
          else     minsD = inc60(minsQ);
        end
      end else if (tick1) begin
        secsD = inc60(secsQ);
        if (secsQ == 6'd59) minsD = inc60(minsQ);
      end
    end
  end

  // Display multiplexer. an/seg are registered from the current index, so
  // the first digit is driven on the first clock after reset release.
  always_comb begin
    refD = (refQ == REF_LAST) ? '0 : refQ + REF_W'(1);
    idxD = (refQ == REF_LAST) ? idxQ + 2'd1 : idxQ;
    case (idxQ)
      2'd0:    digitVal = onesOf(secsQ);
      2'd1:    digitVal = tensOf(secsQ);
      2'd2:    digitVal = onesOf(minsQ);
      default: digitVal = tensOf(minsQ);
    endcase
    anD  = ~(4'b0001 << idxQ);
    segD = {1'b1, sevenSeg(digitVal)};
`ifdef ADJ_BLINK_EN
    // idxQ[1] set means a minutes digit; blank the field being adjusted.
    if (adjMode && phaseQ && (sel ? !idxQ[1] : idxQ[1])) anD = 4'b1111;
`endif
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divQ   <= '0;
      phaseQ <= 1'b0;
      minsQ  <= 6'd0;
      secsQ  <= 6'd0;
      refQ   <= '0;
      idxQ   <= 2'd0;
      anQ    <= 4'b1111;
      segQ   <= 8'hFF;
    end else begin
      divQ   <= divD;
      phaseQ <= phaseD;
      minsQ  <= minsD;
      secsQ  <= secsD;
      refQ   <= refD;
      idxQ   <= idxD;
      anQ    <= anD;
      segQ   <= segD;
    end
  end

  assign mins = minsQ;
  assign secs = secsQ;
  assign an   = anQ;
  assign seg  = segQ;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
//   Directed bench for stopwatch_core with CLK_HZ=8 (tick2 every 4 clocks,
//   tick1 every 8) and REFRESH_DIV=2 (each digit held 2 clocks). Inputs are
//   driven on falling edges and outputs sampled there, so every step below
//   moves exactly one rising edge. T in comments counts rising edges since
//   the last reset release.

module tb_stopwatch_core;

  logic       clk;
  logic       reset;
  logic       pause;
  logic       sel;
  logic [1:0] adj;
  logic [5:0] mins;
  logic [5:0] secs;
  logic [7:0] seg;
  logic [3:0] an;

  int compared   = 0;
  int mismatched = 0;

  stopwatch_core #(
    .CLK_HZ(8),
    .REFRESH_DIV(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pause(pause),
    .sel(sel),
    .adj(adj),
    .mins(mins),
    .secs(secs),
    .seg(seg),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic p, input logic s, input logic [1:0] a);
    pause = p;
    sel   = s;
    adj   = a;
  endtask

  task automatic stepClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkTime(input string tag, input logic [5:0] expMins,
                           input logic [5:0] expSecs);
    checkOutput({tag, "_mins"}, {2'b00, mins}, {2'b00, expMins});
    checkOutput({tag, "_secs"}, {2'b00, secs}, {2'b00, expSecs});
  endtask

  logic [3:0] expAn  [4];
  logic [7:0] expSeg [4];

  initial begin
    expAn[0] = 4'b1110;  expSeg[0] = 8'h99;
    expAn[1] = 4'b1101;  expSeg[1] = 8'hB0;
    expAn[2] = 4'b1011;  expSeg[2] = 8'hA4;
    expAn[3] = 4'b0111;  expSeg[3] = 8'hF9;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00);
    stepClocks(3);
    checkTime("rst_hold", 6'd0, 6'd0);
    checkOutput("rst_hold_an", {4'h0, an}, 8'h0F);
    checkOutput("rst_hold_seg", seg, 8'hFF);

    // Run a little, then reset asynchronously mid-run.
    reset = 1'b0;
    stepClocks(20);
    checkTime("prerst", 6'd0, 6'd2);
    reset = 1'b1;
    #1;
    checkTime("async_rst", 6'd0, 6'd0);
    checkOutput("async_rst_an", {4'h0, an}, 8'h0F);
    checkOutput("async_rst_seg", seg, 8'hFF);

    // Release; T=0 from here.
    @(negedge clk);
    reset = 1'b0;
    stepClocks(1);
    checkOutput("first_an", {4'h0, an}, 8'h0E);
    checkOutput("first_seg", seg, 8'hC0);
    stepClocks(6);
    checkTime("t7", 6'd0, 6'd0);
    stepClocks(1);
    checkTime("t8", 6'd0, 6'd1);
    stepClocks(32);
    checkTime("t40", 6'd0, 6'd5);

    // Seconds carry into minutes at T=480.
    stepClocks(439);
    checkTime("t479", 6'd0, 6'd59);
    stepClocks(1);
    checkTime("t480", 6'd1, 6'd0);

    // Adjust minutes with adj=01; tick2 at T=484, 488, ...
    applyStimulus(1'b0, 1'b0, 2'b01);
    stepClocks(4);
    checkTime("adjm_1", 6'd2, 6'd0);
    stepClocks(4);
    checkTime("adjm_2", 6'd3, 6'd0);
    stepClocks(224);
    checkTime("adjm_59", 6'd59, 6'd0);
    stepClocks(4);
    checkTime("adjm_wrap", 6'd0, 6'd0);

    // Same with adj=10.
    applyStimulus(1'b0, 1'b0, 2'b10);
    stepClocks(4);
    checkTime("adjm10_1", 6'd1, 6'd0);
    stepClocks(232);
    checkTime("adjm10_59", 6'd59, 6'd0);

    // Adjust seconds from T=952.
    applyStimulus(1'b0, 1'b1, 2'b01);
    stepClocks(4);
    checkTime("adjs_1", 6'd59, 6'd1);
    stepClocks(232);
    checkTime("adjs_59", 6'd59, 6'd59);
    stepClocks(4);
    checkTime("adjs_wrap", 6'd59, 6'd0);
    stepClocks(236);
    checkTime("adjs_5959", 6'd59, 6'd59);

    // Back to normal at T=1428; next tick1 at T=1432 wraps to 00:00.
    applyStimulus(1'b0, 1'b0, 2'b00);
    stepClocks(3);
    checkTime("pre_wrap", 6'd59, 6'd59);
    stepClocks(1);
    checkTime("full_wrap", 6'd0, 6'd0);

    // Pause in normal mode for 40 clocks.
    applyStimulus(1'b1, 1'b0, 2'b00);
    stepClocks(40);
    checkTime("pause_norm", 6'd0, 6'd0);
    applyStimulus(1'b0, 1'b0, 2'b00);
    stepClocks(7);
    checkTime("resume_norm_pre", 6'd0, 6'd0);
    stepClocks(1);
    checkTime("resume_norm", 6'd0, 6'd1);

    // Pause in adjust-seconds mode from T=1480.
    applyStimulus(1'b1, 1'b1, 2'b01);
    stepClocks(40);
    checkTime("pause_adj", 6'd0, 6'd1);
    applyStimulus(1'b0, 1'b1, 2'b01);
    stepClocks(3);
    checkTime("resume_adj_pre", 6'd0, 6'd1);
    stepClocks(1);
    checkTime("resume_adj", 6'd0, 6'd2);

    // Set 12:34 via adjust, then freeze it.
    stepClocks(128);
    checkTime("set_secs", 6'd0, 6'd34);
    applyStimulus(1'b0, 1'b0, 2'b01);
    stepClocks(48);
    checkTime("set_mins", 6'd12, 6'd34);
    applyStimulus(1'b1, 1'b0, 2'b00);

    // T=1700; the next fresh digit-0 slot starts at T=1705.
    stepClocks(5);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        checkOutput($sformatf("disp_an_%0d_%0d", k, c), {4'h0, an}, {4'h0, expAn[k]});
        checkOutput($sformatf("disp_seg_%0d_%0d", k, c), seg, expSeg[k]);
        stepClocks(1);
      end
    end
    checkOutput("disp_an_wrap", {4'h0, an}, 8'h0E);
    checkTime("disp_frozen", 6'd12, 6'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
